guess_entry_ctrl: RTL

GUESS_ENTRY_CTRL -- requirements
Module: guess_entry_ctrl

---
 rtl/guess_entry_ctrl_pkg.sv | 17 +
 rtl/guess_entry_ctrl_if.sv | 38 +++
 rtl/guess_history_ram.sv | 58 +++++
 rtl/guess_entry_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/guess_entry_ctrl_pkg.sv
// Shared game constants and FSM encoding for the guess-entry, display and
// colour-checker blocks.
package guess_entry_ctrl_pkg;

  localparam int LETTER_MAX   = 25;
  localparam int WORD_LETTERS = 5;

  localparam logic [WORD_LETTERS-1:0] ALL_GREEN = '1;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_COMMIT = 2'd1,
    ST_WON    = 2'd2,
    ST_LOST   = 2'd3
  } state_e;

endpackage

// File: rtl/guess_entry_ctrl_if.sv
// Keyboard/checker/history bundle between the entry controller and the game shell.
interface guess_entry_ctrl_if
  import guess_entry_ctrl_pkg::*;
#(
  parameter int LETTER_W = 5
);
  logic                             letter_valid;
  logic [LETTER_W-1:0]              letter_code;
  logic                             back_pulse;
  logic                             enter_pulse;
  logic                             new_game;
  logic [WORD_LETTERS*LETTER_W-1:0] guess_word;
  logic [WORD_LETTERS-1:0]          greens_in;
  logic [WORD_LETTERS-1:0]          yellows_in;
  logic [2:0]                       letter_count;
  logic [2:0]                       attempt;
  logic [2:0]                       rd_row;
  logic [WORD_LETTERS*LETTER_W-1:0] rd_word;
  logic [WORD_LETTERS-1:0]          rd_greens;
  logic [WORD_LETTERS-1:0]          rd_yellows;
  logic                             won;
  logic                             lost;
  logic                             row_done;

  modport slave (
    input  letter_valid, letter_code, back_pulse, enter_pulse, new_game,
           greens_in, yellows_in, rd_row,
    output guess_word, letter_count, attempt, rd_word, rd_greens, rd_yellows,
           won, lost, row_done
  );

  modport master (
    output letter_valid, letter_code, back_pulse, enter_pulse, new_game,
           greens_in, yellows_in, rd_row,
    input  guess_word, letter_count, attempt, rd_word, rd_greens, rd_yellows,
           won, lost, row_done
  );
endinterface

// File: rtl/guess_history_ram.sv
// Per-game guess history: one write port, combinational read, bulk clear.
module guess_history_ram
  import guess_entry_ctrl_pkg::*;
#(
  parameter int ROWS     = 6,
  parameter int LETTER_W = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic                             we_i,
  input  logic [2:0]                       wr_row_i,
  input  logic [WORD_LETTERS*LETTER_W-1:0] wr_word_i,
  input  logic [WORD_LETTERS-1:0]          wr_greens_i,
  input  logic [WORD_LETTERS-1:0]          wr_yellows_i,
  input  logic [2:0]                       rd_row_i,
  output logic [WORD_LETTERS*LETTER_W-1:0] rd_word_o,
  output logic [WORD_LETTERS-1:0]          rd_greens_o,
  output logic [WORD_LETTERS-1:0]          rd_yellows_o
);

  logic [WORD_LETTERS*LETTER_W-1:0] word_q [ROWS];
  logic [WORD_LETTERS-1:0]          grn_q  [ROWS];
  logic [WORD_LETTERS-1:0]          yel_q  [ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        word_q[r] <= '0;
        grn_q[r]  <= '0;
        yel_q[r]  <= '0;
      end
    end else if (clr_i) begin
      for (int r = 0; r < ROWS; r++) begin
        word_q[r] <= '0;
        grn_q[r]  <= '0;
        yel_q[r]  <= '0;
      end
    end else if (we_i && int'(wr_row_i) < ROWS) begin
      word_q[wr_row_i] <= wr_word_i;
      grn_q[wr_row_i]  <= wr_greens_i;
      yel_q[wr_row_i]  <= wr_yellows_i;
    end
  end

  // Rows beyond the game length read as empty rather than aliasing.
  always_comb begin
    rd_word_o    = '0;
    rd_greens_o  = '0;
    rd_yellows_o = '0;
    if (int'(rd_row_i) < ROWS) begin
      rd_word_o    = word_q[rd_row_i];
      rd_greens_o  = grn_q[rd_row_i];
      rd_yellows_o = yel_q[rd_row_i];
    end
  end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Word entry controller: collects typed letters, commits rows to history,
// and tracks win/loss for one game.
module guess_entry_ctrl
  import guess_entry_ctrl_pkg::*;
#(
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 5
) (
  input logic              clk,
  input logic              rst_n,
  guess_entry_ctrl_if.slave bus
);

  state_e                                 state_q;
  logic [WORD_LETTERS-1:0][LETTER_W-1:0]  word_q;
  logic [2:0]                             cnt_q;
  logic [2:0]                             attempt_q;
  logic                                   won_q, lost_q;

  logic       commit_we;
  logic       letter_ok;
  logic [2:0] attempt_d;

  assign letter_ok = (int'(cnt_q) < WORD_LETTERS) &&
                     (int'(bus.letter_code) <= LETTER_MAX);
  assign attempt_d = attempt_q + 3'd1;
  // A new_game arriving in the commit cycle cancels the commit, so the
  // pulse must be qualified combinationally rather than pre-registered.
  assign commit_we = (state_q == ST_COMMIT) && !bus.new_game;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ENTRY;
      word_q    <= '0;
      cnt_q     <= '0;
      attempt_q <= '0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else if (bus.new_game) begin
      state_q   <= ST_ENTRY;
      word_q    <= '0;
      cnt_q     <= '0;
      attempt_q <= '0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (bus.enter_pulse) begin
            if (int'(cnt_q) == WORD_LETTERS) state_q <= ST_COMMIT;
          end else if (bus.back_pulse) begin
            if (cnt_q != 3'd0) begin
              word_q[cnt_q - 3'd1] <= '0;
              cnt_q                <= cnt_q - 3'd1;
            end
          end else if (bus.letter_valid && letter_ok) begin
            word_q[cnt_q] <= bus.letter_code;
            cnt_q         <= cnt_q + 3'd1;
          end
        end
        ST_COMMIT: begin
          attempt_q <= attempt_d;
          word_q    <= '0;
          cnt_q     <= '0;
          if (bus.greens_in == ALL_GREEN) begin
            state_q <= ST_WON;
            won_q   <= 1'b1;
          end else if (attempt_d == 3'(MAX_GUESSES)) begin
            state_q <= ST_LOST;
            lost_q  <= 1'b1;
          end else begin
            state_q <= ST_ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

  guess_history_ram #(
    .ROWS     (MAX_GUESSES),
    .LETTER_W (LETTER_W)
  ) u_hist (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (bus.new_game),
    .we_i         (commit_we),
    .wr_row_i     (attempt_q),
    .wr_word_i    (word_q),
    .wr_greens_i  (bus.greens_in),
    .wr_yellows_i (bus.yellows_in),
    .rd_row_i     (bus.rd_row),
    .rd_word_o    (bus.rd_word),
    .rd_greens_o  (bus.rd_greens),
    .rd_yellows_o (bus.rd_yellows)
  );

  assign bus.guess_word   = word_q;
  assign bus.letter_count = cnt_q;
  assign bus.attempt      = attempt_q;
  assign bus.won          = won_q;
  assign bus.lost         = lost_q;
  assign bus.row_done     = commit_we;

endmodule
